// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector, captures y per vector.
// Optional golden-table compare is enabled by defining SWEEP_COMPARE_EN.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] table_out,
  output logic                 mismatch,
  output logic [N_IN-1:0]      fail_idx,
  output logic                 pass
);

  localparam int W = 1 << N_IN;
  localparam logic [3:0] SET_LAST =
    4'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  // With no settle time the sweep skips DRIVE entirely.
  localparam state_e HOLD_ST =
    (SETTLE == 0) ? SAMPLE : DRIVE;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    tbl_q, tbl_d;
  logic            mm_q, mm_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            pass_q, pass_d;
  logic [3:0]      cnt_q, cnt_d;

`ifndef SWEEP_COMPARE_EN
  logic unused_expected;
  assign unused_expected = ^expected;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tbl_d   = tbl_q;
    mm_d    = mm_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          busy_d  = 1'b1;
          tbl_d   = '0;
          mm_d    = 1'b0;
          fail_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = HOLD_ST;
        end
      end
      DRIVE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        tbl_d[vec_q] = y_in;
`ifdef SWEEP_COMPARE_EN
        if (y_in != expected[vec_q] && !mm_q) begin
          mm_d   = 1'b1;
          fail_d = vec_q;
        end
`endif
        if (vec_q != '1) begin
          vec_d   = vec_q + N_IN'(1);
          state_d = HOLD_ST;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef SWEEP_COMPARE_EN
          pass_d  = !mm_d;
`endif
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      mm_q    <= 1'b0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
      mm_q    <= mm_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = tbl_q;
  assign mismatch  = mm_q;
  assign fail_idx  = fail_q;
  assign pass      = pass_q;

endmodule
